alu_exec_cdb_driver: RTL and testbench



---
 rtl/alu_exec_cdb_driver.sv | 179 +++++++++++++++++
 tb/tb_alu_exec_cdb_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_cdb_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_cdb_driver (with mips_core_pkg)
// Brief    : ALU execute unit, multi-cycle multiply, result FIFO, CDB driver.
// Revision : 1.0 - initial release
// ============================================================================

package mips_core_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_SLL  = 4'd10,
        ALU_SRL  = 4'd11,
        ALU_SRA  = 4'd12,
        ALU_LUI  = 4'd13,
        ALU_MUL  = 4'd14,
        ALU_NOP  = 4'd15
    } alu_ctl_t;
endpackage

module alu_exec_cdb_driver
    import mips_core_pkg::*;
#(
    parameter int RESULT_DEPTH = 4,
    parameter int MUL_LATENCY  = 4,
    parameter int TAG_WIDTH    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs_valid,
    input  alu_ctl_t             rs_alu_ctl,
    input  logic [TAG_WIDTH-1:0] rs_tag,
    input  logic [31:0]          rs_op1,
    input  logic [31:0]          rs_op2,
    input  logic                 flush,
    input  logic                 cdb_grant,
    output logic                 stall,
    output logic                 cdb_valid,
    output logic [TAG_WIDTH-1:0] cdb_tag,
    output logic [31:0]          cdb_data,
    output logic                 mul_busy
);

    localparam int PW   = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int MCW  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [CNTW-1:0] c_FULL     = CNTW'(RESULT_DEPTH);
    localparam logic [MCW-1:0]  c_MUL_LOAD = MCW'(MUL_LATENCY - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]           r_state;
    logic [MCW-1:0]       r_mul_cnt;
    logic [TAG_WIDTH-1:0] r_mul_tag;
    logic [31:0]          r_mul_data;

    logic [TAG_WIDTH-1:0] r_tag_mem  [RESULT_DEPTH];
    logic [31:0]          r_data_mem [RESULT_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CNTW-1:0]      r_count;

    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_mul_done;
    logic                 w_push;
    logic                 w_pop;
    logic [TAG_WIDTH-1:0] w_push_tag;
    logic [31:0]          w_push_data;
    logic [31:0]          w_alu_result;
    logic [31:0]          w_mul_product;

    assign mul_busy  = (r_state == S_BUSY);
    assign stall     = (r_count == c_FULL) || mul_busy;
    assign w_accept  = rs_valid && !stall && !flush;
    assign w_is_mul  = (rs_alu_ctl == ALU_MUL);

    assign cdb_valid = (r_count != '0);
    assign cdb_tag   = r_tag_mem[r_rd_ptr];
    assign cdb_data  = r_data_mem[r_rd_ptr];

    assign w_mul_product = rs_op1 * rs_op2;
    assign w_mul_done    = mul_busy && (r_mul_cnt == '0);
    // Accept cannot happen in BUSY, so the two push sources are exclusive.
    assign w_push      = (w_accept && !w_is_mul) || w_mul_done;
    assign w_push_tag  = w_mul_done ? r_mul_tag  : rs_tag;
    assign w_push_data = w_mul_done ? r_mul_data : w_alu_result;
    assign w_pop       = cdb_valid && cdb_grant && !flush;

    always_comb begin
        w_alu_result = 32'h0;
        case (rs_alu_ctl)
            ALU_ADD, ALU_ADDU: w_alu_result = rs_op1 + rs_op2;
            ALU_SUB, ALU_SUBU: w_alu_result = rs_op1 - rs_op2;
            ALU_AND:  w_alu_result = rs_op1 & rs_op2;
            ALU_OR:   w_alu_result = rs_op1 | rs_op2;
            ALU_XOR:  w_alu_result = rs_op1 ^ rs_op2;
            ALU_NOR:  w_alu_result = ~(rs_op1 | rs_op2);
            ALU_SLT:  w_alu_result = {31'h0, $signed(rs_op1) < $signed(rs_op2)};
            ALU_SLTU: w_alu_result = {31'h0, rs_op1 < rs_op2};
            ALU_SLL:  w_alu_result = rs_op2 << rs_op1[4:0];
            ALU_SRL:  w_alu_result = rs_op2 >> rs_op1[4:0];
            ALU_SRA:  w_alu_result = $signed(rs_op2) >>> rs_op1[4:0];
            ALU_LUI:  w_alu_result = {rs_op2[15:0], 16'h0};
            default:  w_alu_result = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mul_cnt  <= '0;
            r_mul_tag  <= '0;
            r_mul_data <= '0;
        end else if (flush) begin
            r_state   <= S_IDLE;
            r_mul_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state    <= S_BUSY;
                        r_mul_cnt  <= c_MUL_LOAD;
                        r_mul_tag  <= rs_tag;
                        r_mul_data <= w_mul_product;
                    end
                end
                S_BUSY: begin
                    if (r_mul_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_mul_cnt <= r_mul_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage is reset too so the CDB bus reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESULT_DEPTH; i++) begin
                r_tag_mem[i]  <= '0;
                r_data_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr]  <= w_push_tag;
                r_data_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_cdb_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_cdb_driver
// Brief    : Directed self-checking bench for alu_exec_cdb_driver.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_exec_cdb_driver;
    import mips_core_pkg::*;

    localparam int TW = 5;

    logic          clk;
    logic          rst_n;
    logic          rs_valid;
    alu_ctl_t      rs_alu_ctl;
    logic [TW-1:0] rs_tag;
    logic [31:0]   rs_op1;
    logic [31:0]   rs_op2;
    logic          flush;
    logic          cdb_grant;
    logic          stall;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic          mul_busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [TW-1:0] r_seen [$];

    alu_exec_cdb_driver #(
        .RESULT_DEPTH (4),
        .MUL_LATENCY  (4),
        .TAG_WIDTH    (TW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_valid   (rs_valid),
        .rs_alu_ctl (rs_alu_ctl),
        .rs_tag     (rs_tag),
        .rs_op1     (rs_op1),
        .rs_op2     (rs_op2),
        .flush      (flush),
        .cdb_grant  (cdb_grant),
        .stall      (stall),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .mul_busy   (mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Presents one instruction for one edge, then returns at the next negedge.
    task automatic issue(input alu_ctl_t ctl, input logic [TW-1:0] tag,
                         input logic [31:0] a, input logic [31:0] b);
        rs_valid   = 1'b1;
        rs_alu_ctl = ctl;
        rs_tag     = tag;
        rs_op1     = a;
        rs_op2     = b;
        @(posedge clk);
        @(negedge clk);
        rs_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rs_valid = 1'b0; rs_alu_ctl = ALU_NOP; rs_tag = '0;
        rs_op1 = '0; rs_op2 = '0; flush = 1'b0; cdb_grant = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_tag", 32'(cdb_tag), 32'd0);
        check("rst_data", cdb_data, 32'd0);
        check("rst_mulbusy", 32'(mul_busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Single-cycle ops, grant held high
        cdb_grant = 1'b1;
        issue(ALU_ADDU, 5'd3, 32'd5, 32'd7);
        check("addu_valid", 32'(cdb_valid), 32'd1);
        check("addu_tag", 32'(cdb_tag), 32'd3);
        check("addu_data", cdb_data, 32'd12);
        step();
        check("addu_popped", 32'(cdb_valid), 32'd0);

        issue(ALU_SLT, 5'd4, 32'hFFFF_FFFF, 32'd1);
        check("slt_data", cdb_data, 32'd1);
        issue(ALU_SLTU, 5'd5, 32'hFFFF_FFFF, 32'd1);
        check("sltu_data", cdb_data, 32'd0);
        check("sltu_tag", 32'(cdb_tag), 32'd5);
        issue(ALU_SRA, 5'd6, 32'd4, 32'h8000_0000);
        check("sra_data", cdb_data, 32'hF800_0000);
        issue(ALU_SUB, 5'd7, 32'd3, 32'd5);
        check("sub_data", cdb_data, 32'hFFFF_FFFE);
        issue(ALU_NOR, 5'd8, 32'h0F0F_0000, 32'h0000_00FF);
        check("nor_data", cdb_data, 32'hF0F0_FF00);
        issue(ALU_LUI, 5'd9, 32'd0, 32'h1234_ABCD);
        check("lui_data", cdb_data, 32'hABCD_0000);
        issue(ALU_SRL, 5'd10, 32'd36, 32'h8000_0000);
        check("srl_data", cdb_data, 32'h0800_0000);
        step();
        check("ops_drained", 32'(cdb_valid), 32'd0);

        // MUL with an ADD waiting behind it
        issue(ALU_MUL, 5'd20, 32'd6, 32'd7);
        rs_valid = 1'b1; rs_alu_ctl = ALU_ADD; rs_tag = 5'd21; rs_op1 = 32'd1; rs_op2 = 32'd2;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mul_stall%0d", i), 32'(stall), 32'd1);
            check($sformatf("mul_busy%0d", i), 32'(mul_busy), 32'd1);
            check($sformatf("mul_novalid%0d", i), 32'(cdb_valid), 32'd0);
            step();
        end
        check("mul_done_busy", 32'(mul_busy), 32'd0);
        check("mul_done_stall", 32'(stall), 32'd0);
        check("mul_tag", 32'(cdb_tag), 32'd20);
        check("mul_data", cdb_data, 32'd42);
        step();
        rs_valid = 1'b0;
        check("add_after_mul_tag", 32'(cdb_tag), 32'd21);
        check("add_after_mul_data", cdb_data, 32'd3);
        step();
        check("mul_drained", 32'(cdb_valid), 32'd0);

        // Fill FIFO with grant low, then drain in order
        cdb_grant = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            rs_valid = 1'b1; rs_alu_ctl = ALU_ADD; rs_tag = TW'(t);
            rs_op1 = 32'(t); rs_op2 = 32'd100;
            step();
        end
        check("full_stall", 32'(stall), 32'd1);
        check("full_head_tag", 32'(cdb_tag), 32'd1);
        check("full_head_data", cdb_data, 32'd101);
        cdb_grant = 1'b1;
        r_seen.delete();
        r_seen.push_back(cdb_tag);
        step();
        check("unfull_stall", 32'(stall), 32'd0);
        r_seen.push_back(cdb_tag);
        step();
        rs_valid = 1'b0;
        for (int i = 0; i < 10 && cdb_valid; i++) begin
            r_seen.push_back(cdb_tag);
            if (cdb_tag == 5'd5) check("tag5_data", cdb_data, 32'd105);
            step();
        end
        check("drain_count", 32'(r_seen.size()), 32'd5);
        for (int i = 0; i < r_seen.size() && i < 5; i++)
            check($sformatf("drain_order%0d", i), 32'(r_seen[i]), 32'(i + 1));

        // Flush with 2 queued results and a MUL in flight
        cdb_grant = 1'b0;
        issue(ALU_ADD, 5'd11, 32'd1, 32'd1);
        issue(ALU_ADD, 5'd12, 32'd2, 32'd2);
        issue(ALU_MUL, 5'd13, 32'd3, 32'd3);
        check("pre_flush_busy", 32'(mul_busy), 32'd1);
        rs_valid = 1'b1; rs_alu_ctl = ALU_ADD; rs_tag = 5'd14;
        flush = 1'b1; cdb_grant = 1'b1;
        step();
        flush = 1'b0; rs_valid = 1'b0;
        check("flush_valid", 32'(cdb_valid), 32'd0);
        check("flush_busy", 32'(mul_busy), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("flush_quiet%0d", i), 32'(cdb_valid), 32'd0);
        end

        // Asynchronous reset between edges
        cdb_grant = 1'b0;
        issue(ALU_ADD, 5'd15, 32'd1, 32'd1);
        issue(ALU_ADD, 5'd16, 32'd1, 32'd1);
        check("prereset_valid", 32'(cdb_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", 32'(cdb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cdb_grant = 1'b1;
        step();
        step();
        check("post_rst_valid", 32'(cdb_valid), 32'd0);
        check("post_rst_tag", 32'(cdb_tag), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
